// File: rtl/ctx_pkg.sv
// ctx_pkg: shared sizes, context field offsets and loader FSM encoding
// Ports: none (package)
package ctx_pkg;
    localparam int CM_AW       = 6;
    localparam int CM_DW       = 60;
    localparam int IN_W        = 16;
    localparam int BEATS       = 4;
    localparam int BEAT_CW     = $clog2(BEATS);
    localparam int LAST_W      = CM_DW - (BEATS - 1) * IN_W;
    localparam int PAD_W       = IN_W - LAST_W;
    localparam int PE_CFG_W    = 7;
    localparam int DM_CTRL_W   = 8;
    localparam int DM_CTRL_LSB = 28;
    localparam logic [BEAT_CW-1:0] LAST_BEAT = BEAT_CW'(BEATS - 1);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WRITE, ST_DONE} state_e;
endpackage

// File: rtl/ctx_beat_packer.sv
// ctx_beat_packer: assembles BEATS stream beats into one context word, flags pad errors
// Ports: clk, rst_n (async active-low), clear_i restarts packing, beat_i/data_i one accepted beat,
//        word_o word including the current beat, full_o final beat accepted, pad_err_o nonzero pad bits
module ctx_beat_packer
    import ctx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             beat_i,
    input  logic [IN_W-1:0]  data_i,
    output logic [CM_DW-1:0] word_o,
    output logic             full_o,
    output logic             pad_err_o
);
    logic [BEAT_CW-1:0] cnt_q, cnt_d;
    logic [CM_DW-1:0]   word_q;

    always_comb begin
        word_o = word_q;
        full_o = beat_i && cnt_q == LAST_BEAT;
        // the final beat only carries LAST_W payload bits; the rest is pad and is dropped
        if (full_o) word_o[CM_DW-1 -: LAST_W] = data_i[LAST_W-1:0];
        else if (beat_i) word_o[cnt_q*IN_W +: IN_W] = data_i;
        pad_err_o = full_o && data_i[IN_W-1 -: PAD_W] != '0;
        cnt_d = clear_i ? '0 : cnt_q + BEAT_CW'(beat_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= clear_i ? '0 : word_o;
        end
    end
endmodule

// File: rtl/context_loader.sv
// context_loader: packs a 16-bit valid/ready stream into 60-bit words written to consecutive context addresses
// Ports: clk, rst_n (async active-low), start_i/base_addr_i/ctx_count_i load request,
//        in_valid_i/in_data_i/in_ready_o beat stream, wr_cm_en_o/cm_addr_o/wr_cm_data_o memory write,
//        busy_o load in progress, done_o end-of-load pulse, err_o sticky pad error
module context_loader
    import ctx_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [CM_AW-1:0] base_addr_i,
    input  logic [CM_AW:0]   ctx_count_i,
    input  logic             in_valid_i,
    input  logic [IN_W-1:0]  in_data_i,
    output logic             in_ready_o,
    output logic             wr_cm_en_o,
    output logic [CM_AW-1:0] cm_addr_o,
    output logic [CM_DW-1:0] wr_cm_data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o
);
    state_e           state_q, state_d;
    logic [CM_AW-1:0] base_q, base_d, addr_q, addr_d;
    logic [CM_AW:0]   cnt_q, cnt_d, idx_q, idx_d;
    logic [CM_DW-1:0] data_q, data_d, word;
    logic             ready_q, ready_d, wr_q, wr_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             clear, beat, full, pad_err;

    assign beat = in_valid_i & ready_q;

    ctx_beat_packer u_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (clear),
        .beat_i   (beat),
        .data_i   (in_data_i),
        .word_o   (word),
        .full_o   (full),
        .pad_err_o(pad_err)
    );

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = full ? word : data_q;
        err_d   = err_q | pad_err;
        clear   = 1'b0;
        case (state_q)
            ST_IDLE: if (start_i) begin
                base_d  = base_addr_i;
                cnt_d   = ctx_count_i;
                idx_d   = '0;
                err_d   = 1'b0;
                clear   = 1'b1;
                // an empty load still spends one busy cycle in WRITE (strobe suppressed) before DONE
                state_d = ctx_count_i == '0 ? ST_WRITE : ST_LOAD;
            end
            ST_LOAD: if (full) begin
                state_d = ST_WRITE;
                addr_d  = base_q + idx_q[CM_AW-1:0];
            end
            ST_WRITE: begin
                idx_d   = idx_q + 1'b1;
                state_d = (cnt_q == '0 || idx_d == cnt_q) ? ST_DONE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        // outputs are registered from the next state so they line up with the state they describe
        ready_d = state_d == ST_LOAD;
        wr_d    = state_d == ST_WRITE && cnt_d != '0;
        busy_d  = state_d == ST_LOAD || state_d == ST_WRITE;
        done_d  = state_d == ST_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o   = ready_q;
    assign wr_cm_en_o   = wr_q;
    assign cm_addr_o    = addr_q;
    assign wr_cm_data_o = data_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
endmodule

// File: tb/tb_context_loader.sv
// tb_context_loader: randomized load sequences checked against a load-level write model
module tb_context_loader;
    logic        clk, rst_n, start, in_valid, in_ready, wr_cm_en, busy, done, err;
    logic [5:0]  base_addr, cm_addr;
    logic [6:0]  ctx_count;
    logic [15:0] in_data;
    logic [59:0] wr_cm_data;

    typedef struct packed {
        logic [5:0]  a;
        logic [59:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          addr_log[$];
    int          wr_cyc[$];
    logic [15:0] fix_beats[8];
    logic [59:0] last_data;
    int          last_addr, cyc, done_cyc, n_wr, n_done, n_busy, n_pass, n_tot, mon_beats;
    bit          pend;

    context_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .base_addr_i (base_addr),
        .ctx_count_i (ctx_count),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .wr_cm_en_o  (wr_cm_en),
        .cm_addr_o   (cm_addr),
        .wr_cm_data_o(wr_cm_data),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    // compare process: every write must be the next expected one, one cycle after a 4th beat
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst_n) begin
            chk("reset_outs", {in_ready, wr_cm_en, cm_addr, busy, done, err}, '0);
            chk("reset_data", wr_cm_data, '0);
            mon_beats = 0;
            pend = 0;
            last_data = '0;
        end else begin
            chk("wr_timing", wr_cm_en, pend);
            if (wr_cm_en) begin
                chk("ready_in_write", in_ready, 0);
                n_wr++;
                wr_cyc.push_back(cyc);
                addr_log.push_back(int'(cm_addr));
                last_data = wr_cm_data;
                last_addr = int'(cm_addr);
                if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", cm_addr, e.a);
                    chk("wr_data", wr_cm_data, e.d);
                end
            end else chk("data_hold", wr_cm_data, last_data);
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (busy) n_busy++;
            pend = in_valid && in_ready && mon_beats == 3;
            if (in_valid && in_ready) mon_beats = (mon_beats + 1) % 4;
        end
    end

    task automatic feed(input logic [15:0] d, input bit rnd);
        int t;
        bit r;
        if (rnd) repeat ($urandom_range(0, 2)) begin
            in_valid = 0;
            in_data = 16'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1;
        in_data = d;
        t = 0;
        do begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk); #1;
            t++;
        end while (!r && t < 40);
        in_valid = 0;
        if (!r) chk("beat_timeout", 0, 1);
    endtask

    task automatic spurious_start();
        in_valid = 0;
        start = 1;
        base_addr = 6'($urandom);
        ctx_count = 7'($urandom_range(1, 64));
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic do_load(input int base, input int cnt, input bit rnd, input bit spur, input bit fixed, output int s);
        logic [15:0] bt[4];
        logic [59:0] w;
        bit e;
        int t;
        bit got;
        e = 0;
        @(posedge clk); #1;
        start = 1;
        base_addr = 6'(base);
        ctx_count = 7'(cnt);
        s = cyc + 1;
        @(posedge clk); #1;
        start = 0;
        base_addr = 6'($urandom);
        ctx_count = 7'($urandom);
        for (int c = 0; c < cnt; c++) begin
            for (int b = 0; b < 4; b++) begin
                bt[b] = fixed ? fix_beats[(c * 4 + b) % 8] : 16'($urandom);
                if (!fixed && b == 3 && $urandom_range(0, 7) != 0) bt[b][15:12] = 4'h0;
            end
            w = {bt[3][11:0], bt[2], bt[1], bt[0]};
            if (bt[3][15:12] != 0) e = 1;
            exp_q.push_back('{a: 6'((base + c) % 64), d: w});
            for (int b = 0; b < 4; b++) begin
                if (spur && c == 0 && b == 1) spurious_start();
                feed(bt[b], rnd);
            end
        end
        t = 0;
        got = 0;
        while (!got && t < 60) begin
            @(negedge clk); #1;
            got = done;
            t++;
        end
        chk("done_seen", got, 1);
        chk("err_at_done", err, e);
        @(negedge clk); #1;
        chk("done_pulse_busy", {done, busy}, 0);
        chk("writes_drained", exp_q.size(), 0);
    endtask

    initial begin
        int s, n0, d0, b0;
        rst_n = 0; start = 0; in_valid = 0; in_data = 0; base_addr = 0; ctx_count = 0;
        cyc = 0; n_wr = 0; n_done = 0; n_busy = 0; n_pass = 0; n_tot = 0; mon_beats = 0;
        last_data = '0; last_addr = 0; done_cyc = 0; pend = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        chk("post_reset_busy", busy, 0);

        // reset in the middle of a load, then a clean single-context load
        @(posedge clk); #1;
        start = 1; base_addr = 9; ctx_count = 3;
        @(posedge clk); #1;
        start = 0;
        feed(16'hDEAD, 0);
        feed(16'hBEEF, 0);
        rst_n = 0;
        @(negedge clk); #1;
        chk("mid_reset_outs", {busy, in_ready, wr_cm_en, done, err, cm_addr}, '0);
        @(posedge clk); #1;
        rst_n = 1;
        fix_beats = '{16'h1111, 16'h2222, 16'h3333, 16'h0444, 16'h1111, 16'h2222, 16'h3333, 16'h0444};
        n0 = n_wr;
        do_load(0, 1, 0, 0, 1, s);
        chk("t1_one_write", n_wr - n0, 1);
        chk("t1_data", last_data, 60'h444_3333_2222_1111);
        chk("t1_addr", last_addr, 0);

        // back-to-back timing, base 5 count 2
        for (int i = 0; i < 8; i++) fix_beats[i] = 16'($urandom) & ((i % 4 == 3) ? 16'h0FFF : 16'hFFFF);
        wr_cyc.delete();
        addr_log.delete();
        do_load(5, 2, 0, 0, 1, s);
        chk("t2_nwrites", wr_cyc.size(), 2);
        chk("t2_wr0_cycle", wr_cyc.size() > 0 ? wr_cyc[0] : -1, s + 5);
        chk("t2_wr1_cycle", wr_cyc.size() > 1 ? wr_cyc[1] : -1, s + 10);
        chk("t2_done_cycle", done_cyc, s + 11);
        chk("t2_addr0", addr_log.size() > 0 ? addr_log[0] : -1, 5);
        chk("t2_addr1", addr_log.size() > 1 ? addr_log[1] : -1, 6);
        chk("t2_err", err, 0);

        // address wrap
        addr_log.delete();
        d0 = n_done;
        do_load(62, 4, 0, 0, 0, s);
        chk("t3_nwrites", addr_log.size(), 4);
        for (int i = 0; i < 4; i++) chk("t3_wrap_addr", addr_log.size() > i ? addr_log[i] : -1, (62 + i) % 64);
        chk("t3_done_once", n_done - d0, 1);

        // empty load
        n0 = n_wr;
        b0 = n_busy;
        do_load(0, 0, 0, 0, 0, s);
        chk("t4_no_write", n_wr - n0, 0);
        chk("t4_busy_cycles", n_busy - b0, 1);
        chk("t4_done_cycle", done_cyc, s + 2);

        // nonzero pad in the final beat
        fix_beats = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hF123, 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hF123};
        do_load(10, 1, 0, 0, 1, s);
        chk("t5_data", last_data, 60'h123_CCCC_BBBB_AAAA);
        chk("t5_err_set", err, 1);
        repeat (3) @(negedge clk);
        #1 chk("t5_err_held", err, 1);
        do_load(20, 0, 0, 0, 0, s);
        chk("t5_err_cleared", err, 0);

        // random valid, stray starts during LOAD, then a full-depth load
        for (int i = 0; i < 12; i++) do_load($urandom_range(0, 63), $urandom_range(1, 5), 1, i[0], 0, s);
        addr_log.delete();
        do_load($urandom_range(0, 63), 64, 0, 0, 0, s);
        chk("t6_full_depth", addr_log.size(), 64);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
